// File: rtl/gf_mix_columns_unit_pkg.sv
// GF(2^8) helpers and shared types for the AES MixColumns / InvMixColumns unit.
// Constant multipliers are built only from reduced xtime chains and XOR.
package gf_pkg;

  localparam logic [7:0] GF_POLY = 8'h1B;

  typedef logic [7:0]   gf_byte_t;
  typedef logic [31:0]  gf_col_t;
  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mix_fsm_t;

  function automatic gf_byte_t xtime(gf_byte_t a, gf_byte_t poly);
    return {a[6:0], 1'b0} ^ (a[7] ? poly : 8'h00);
  endfunction

  function automatic gf_byte_t gf_mul_const(gf_byte_t a, logic [3:0] k,
                                            gf_byte_t poly = GF_POLY);
    gf_byte_t x1;
    gf_byte_t x2;
    gf_byte_t x3;
    x1 = xtime(a, poly);
    x2 = xtime(x1, poly);
    x3 = xtime(x2, poly);
    case (k)
      4'd1:    return a;
      4'd2:    return x1;
      4'd3:    return x1 ^ a;
      4'd9:    return x3 ^ a;
      4'd11:   return x3 ^ x1 ^ a;
      4'd13:   return x3 ^ x2 ^ a;
      4'd14:   return x3 ^ x2 ^ x1;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/gf_mix_column.sv
// Combinational single-column MixColumns (inverse=0) or InvMixColumns (inverse=1).
// Byte a0 sits in col_in[31:24]; each output row rotates the coefficient vector.
module gf_mix_column
  import gf_pkg::*;
#(
  parameter gf_byte_t POLY = GF_POLY
) (
  input  logic [31:0] col_in,
  input  logic        inverse,
  output logic [31:0] col_out
);

  gf_byte_t   a [4];
  gf_byte_t   b [4];
  logic [3:0] coef [4];

  always_comb begin
    for (int unsigned r = 0; r < 4; r++) begin
      a[r] = col_in[31 - 8*r -: 8];
    end
    if (inverse) begin
      coef[0] = 4'd14; coef[1] = 4'd11; coef[2] = 4'd13; coef[3] = 4'd9;
    end else begin
      coef[0] = 4'd2;  coef[1] = 4'd3;  coef[2] = 4'd1;  coef[3] = 4'd1;
    end
    for (int unsigned r = 0; r < 4; r++) begin
      b[r] = '0;
      for (int unsigned j = 0; j < 4; j++) begin
        b[r] ^= gf_mul_const(a[j], coef[(j + 4 - r) % 4], POLY);
      end
    end
    col_out = {b[0], b[1], b[2], b[3]};
  end

endmodule

// File: rtl/gf_mix_columns_unit.sv
// Multi-cycle AES MixColumns / InvMixColumns engine: LANES columns per cycle,
// transformed in place in a working register, valid/ready on both sides.
module gf_mix_columns_unit
  import gf_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter gf_byte_t    POLY  = GF_POLY
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inverse,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("gf_mix_columns_unit: LANES must be 1, 2 or 4");
  end

  mix_fsm_t   state_q, state_d;
  logic [1:0] col_q;
  logic [2:0] col_sum;
  aes_state_t work_q, work_d;
  logic       mode_q;
  logic       out_valid_q;

  logic [1:0] lane_idx [LANES];
  gf_col_t    lane_in  [LANES];
  gf_col_t    lane_out [LANES];

  // Column c lives at bits [127-32c -: 32], i.e. base offset {~c, 5'b0}.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_idx[l] = col_q + 2'(l);
      lane_in[l]  = work_q[{~lane_idx[l], 5'd0} +: 32];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    gf_mix_column #(.POLY(POLY)) u_col (
      .col_in  (lane_in[l]),
      .inverse (mode_q),
      .col_out (lane_out[l])
    );
  end

  assign col_sum = {1'b0, col_q} + 3'(LANES);

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          work_d  = in_state;
        end
      end
      BUSY: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          work_d[{~lane_idx[l], 5'd0} +: 32] = lane_out[l];
        end
        if (col_sum == 3'd4) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      work_q      <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      out_valid_q <= (state_d == DONE);
      if (state_q == IDLE && in_valid) begin
        mode_q <= in_inverse;
        col_q  <= '0;
      end else if (state_q == BUSY) begin
        col_q <= col_sum[1:0];
      end
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_state = work_q;

endmodule

// File: tb/tb_gf_mix_columns_unit.sv
// Self-checking bench for gf_mix_columns_unit, run side by side at LANES=1, 2, 4
// against a matrix-product reference over GF(2^8) using generic multiplication.
module tb_gf_mix_columns_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst        [3];
  logic         in_valid   [3];
  logic         in_ready   [3];
  logic [127:0] in_state   [3];
  logic         in_inverse [3];
  logic         out_valid  [3];
  logic         out_ready  [3];
  logic [127:0] out_state  [3];
  logic         busy       [3];

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    gf_mix_columns_unit #(.LANES(1 << g), .POLY(8'h1B)) dut (
      .clk        (clk),
      .rst        (rst[g]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_state   (in_state[g]),
      .in_inverse (in_inverse[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_state  (out_state[g]),
      .busy       (busy[g])
    );
  end

  // Shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      b = b >> 1;
      a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(logic [127:0] s, logic inv);
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] r;
    r = '0;
    if (inv) base = '{8'd14, 8'd11, 8'd13, 8'd9};
    else     base = '{8'd2, 8'd3, 8'd1, 8'd1};
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = '0;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(s[127 - 8*(4*c + j) -: 8], base[(j - row + 4) % 4]);
        r[127 - 8*(4*c + row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic check(int d, string name, logic [127:0] act, logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s [LANES=%0d]: got %h expected %h", name, 1 << d, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_ready(int d);
    int n = 0;
    while (!in_ready[d] && n < 50) begin tick(); n++; end
    if (!in_ready[d]) check(d, "in_ready_timeout", 0, 1);
  endtask

  task automatic wait_out(int d, output int lat);
    lat = 0;
    while (!out_valid[d] && lat < 50) begin tick(); lat++; end
    if (!out_valid[d]) check(d, "out_valid_timeout", 0, 1);
  endtask

  task automatic transact(int d, logic [127:0] s, logic inv,
                          output logic [127:0] res, output int lat);
    in_state[d] = s; in_inverse[d] = inv; in_valid[d] = 1'b1;
    wait_ready(d);
    tick();
    in_valid[d] = 1'b0;
    wait_out(d, lat);
    res = out_state[d];
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
  endtask

  task automatic do_reset();
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
      in_state[d] = '0; in_inverse[d] = 1'b0;
    end
    tick(); tick();
    for (int d = 0; d < 3; d++) begin
      check(d, "rst_out_valid", out_valid[d], 0);
      check(d, "rst_busy", busy[d], 0);
      check(d, "rst_out_state", out_state[d], 0);
      check(d, "rst_in_ready", in_ready[d], 0);
      rst[d] = 1'b0;
    end
    #1;
    for (int d = 0; d < 3; d++) check(d, "post_rst_in_ready", in_ready[d], 1);
  endtask

  task automatic backpressure(int d);
    logic [127:0] s, exp;
    int lat;
    s = rnd_state(); exp = model(s, 1'b0);
    in_state[d] = s; in_inverse[d] = 1'b0; in_valid[d] = 1'b1;
    wait_ready(d);
    tick();
    in_valid[d] = 1'b0;
    wait_out(d, lat);
    for (int i = 0; i < 10; i++) begin
      in_valid[d] = i[0]; in_state[d] = rnd_state(); in_inverse[d] = ~i[0];
      tick();
      check(d, "bp_out_state", out_state[d], exp);
      check(d, "bp_in_ready", in_ready[d], 0);
      check(d, "bp_out_valid", out_valid[d], 1);
    end
    in_valid[d] = 1'b0; out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    check(d, "bp_handoff_valid", out_valid[d], 0);
    check(d, "bp_handoff_ready", in_ready[d], 1);
    tick();
    check(d, "bp_single_transfer", out_valid[d], 0);
    check(d, "bp_idle_busy", busy[d], 0);
  endtask

  task automatic back_to_back(int d);
    logic [127:0] reqs [8];
    logic [127:0] exps [8];
    for (int i = 0; i < 8; i++) begin
      reqs[i] = rnd_state();
      exps[i] = model(reqs[i], i[0]);
    end
    out_ready[d] = 1'b1;
    fork
      begin
        int i = 0;
        int cyc = 0;
        logic acc;
        while (i < 8 && cyc < 200) begin
          in_state[d] = reqs[i]; in_inverse[d] = i[0]; in_valid[d] = 1'b1;
          acc = in_ready[d];
          tick(); cyc++;
          if (acc) i++;
        end
        in_valid[d] = 1'b0;
      end
      begin
        int j = 0;
        int cyc = 0;
        int last = 0;
        while (j < 8 && cyc < 300) begin
          if (out_valid[d]) begin
            check(d, "b2b_result", out_state[d], exps[j]);
            // Handoff edge returns to IDLE; the next accept is one edge later.
            if (j > 0) check(d, "b2b_interval", cyc - last, (4 >> d) + 2);
            last = cyc;
            j++;
          end
          tick(); cyc++;
        end
        if (j < 8) check(d, "b2b_timeout", j, 8);
      end
    join
    out_ready[d] = 1'b0;
    tick();
  endtask

  task automatic reset_mid_busy(int d);
    logic [127:0] s, res;
    int lat;
    s = rnd_state();
    in_state[d] = s; in_inverse[d] = 1'b0; in_valid[d] = 1'b1;
    wait_ready(d);
    tick();
    in_valid[d] = 1'b0;
    tick(); tick();
    check(d, "mid_busy_before_rst", busy[d], 1);
    rst[d] = 1'b1;
    tick();
    check(d, "abort_out_valid", out_valid[d], 0);
    check(d, "abort_out_state", out_state[d], 0);
    check(d, "abort_busy", busy[d], 0);
    check(d, "abort_in_ready_in_rst", in_ready[d], 0);
    rst[d] = 1'b0;
    #1;
    check(d, "abort_in_ready_after", in_ready[d], 1);
    s = rnd_state();
    transact(d, s, 1'b1, res, lat);
    check(d, "abort_fresh_result", res, model(s, 1'b1));
  endtask

  typedef struct {
    logic [127:0] st;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  initial begin
    vec_t         tbl [10];
    logic [127:0] res, res2, s;
    int           lat;

    do_reset();

    tbl[0] = '{{4{32'hdb135345}}, 1'b0, {4{32'h8e4da1bc}}};
    tbl[1] = '{{4{32'hf20a225c}}, 1'b0, {4{32'h9fdc589d}}};
    tbl[2] = '{{4{32'hc6c6c6c6}}, 1'b0, {4{32'hc6c6c6c6}}};
    tbl[3] = '{{4{32'hd4d4d4d5}}, 1'b0, {4{32'hd5d5d7d6}}};
    tbl[4] = '{128'hdb135345f20a225cc6c6c6c6d4d4d4d5, 1'b0,
               128'h8e4da1bc9fdc589dc6c6c6c6d5d5d7d6};
    tbl[5] = '{128'h8e4da1bc9fdc589dc6c6c6c6d5d5d7d6, 1'b1,
               128'hdb135345f20a225cc6c6c6c6d4d4d4d5};
    tbl[6] = '{{4{32'h01010101}}, 1'b0, {4{32'h01010101}}};
    tbl[7] = '{{4{32'h01010101}}, 1'b1, {4{32'h01010101}}};
    tbl[8] = '{{4{32'h80808080}}, 1'b0, {4{32'h80808080}}};
    tbl[9] = '{{32'h80000000, 96'h0}, 1'b0, {32'h1b80809b, 96'h0}};

    for (int d = 0; d < 3; d++) begin
      for (int t = 0; t < 10; t++) begin
        transact(d, tbl[t].st, tbl[t].inv, res, lat);
        check(d, $sformatf("vec%0d_result", t), res, tbl[t].exp);
        check(d, $sformatf("vec%0d_latency", t), lat, 4 >> d);
      end
      backpressure(d);
      back_to_back(d);
    end

    for (int d = 0; d < 3; d++) begin
      for (int it = 0; it < 1000; it++) begin
        s = rnd_state();
        transact(d, s, 1'b0, res, lat);
        check(d, "rand_forward", res, model(s, 1'b0));
        transact(d, res, 1'b1, res2, lat);
        check(d, "rand_roundtrip", res2, s);
      end
    end

    reset_mid_busy(0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
